// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode instruction queue interface: fetch packet in, single-word decode handshake out.
// slave = the queue; master = fetch/decode side (or a testbench driving both).
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mask;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst0;
  logic [31:0]      in_inst1;
  logic             in_adel;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_adel;
  logic [CNT_W-1:0] count;

  modport slave (
    input  flush, in_valid, in_mask, in_pc, in_inst0, in_inst1, in_adel, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_adel, count
  );

  modport master (
    output flush, in_valid, in_mask, in_pc, in_inst0, in_inst1, in_adel, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_adel, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer taking up to two words per cycle, handing one per cycle to decode.
// Optional same-cycle empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_queue_if.slave   fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           word0_c, word1_c, first_c, head_c;
  logic [1:0]       n_c, n_store_c;
  logic             empty_c, push_c, pop_c, bypass_c, consume_c;
  logic             wr0_en_c, wr1_en_c;
  logic [PTR_W-1:0] wr1_idx_c;

  assign empty_c     = (count_q == '0);
  assign fq.in_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign fq.count    = count_q;

  assign word0_c = '{pc: fq.in_pc,                 inst: fq.in_inst0, adel: fq.in_adel};
  assign word1_c = '{pc: fq.in_pc + 32'd4,         inst: fq.in_inst1, adel: fq.in_adel};
  assign first_c = (fq.in_mask == 2'b10) ? word1_c : word0_c;
  assign head_c  = mem_q[head_q];

  assign n_c    = 2'({1'b0, fq.in_mask[0]}) + 2'({1'b0, fq.in_mask[1]});
  assign push_c = fq.in_valid & fq.in_ready & ~fq.flush;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass_c = empty_c & push_c & (n_c != 2'd0);
`else
  assign bypass_c = 1'b0;
`endif
  // A bypassed word taken by decode in the same cycle is never stored.
  assign consume_c = bypass_c & fq.out_ready;
  assign pop_c     = ~empty_c & fq.out_ready & ~fq.flush;

  always_comb begin
    n_store_c = 2'd0;
    wr0_en_c  = 1'b0;
    wr1_en_c  = 1'b0;
    wr1_idx_c = tail_q + PTR_W'(1);
    if (push_c) begin
      n_store_c = n_c - 2'({1'b0, consume_c});
      wr0_en_c  = (n_c != 2'd0) & ~consume_c;
      wr1_en_c  = (n_c == 2'd2);
      if (consume_c) begin
        wr1_idx_c = tail_q;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_c);
      tail_d  = tail_q + PTR_W'(n_store_c);
      count_d = count_q + CNT_W'(n_store_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (wr0_en_c) begin
      mem_q[tail_q] <= first_c;
    end
    if (wr1_en_c) begin
      mem_q[wr1_idx_c] <= word1_c;
    end
  end

  always_comb begin
    fq.out_valid = 1'b0;
    fq.out_pc    = 32'h0;
    fq.out_inst  = 32'h0;
    fq.out_adel  = 1'b0;
    if (!empty_c) begin
      fq.out_valid = 1'b1;
      fq.out_pc    = head_c.pc;
      fq.out_inst  = head_c.inst;
      fq.out_adel  = head_c.adel;
    end else if (bypass_c) begin
      fq.out_valid = 1'b1;
      fq.out_pc    = first_c.pc;
      fq.out_inst  = first_c.inst;
      fq.out_adel  = first_c.adel;
    end
  end
endmodule
